// File: rtl/seg_time_display.sv
// Four-digit common-anode 7-segment scanner for a BCD seconds value with timeout/stop status.
// Optional leading-zero blanking of the tens digit: define SEG_TIME_DISPLAY_LZB_EN.
module seg_time_display #(
  parameter int SCAN_DIV  = 12500,
  parameter int BLINK_DIV = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] number,
  input  logic       timeout,
  input  logic       stop,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);

  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [1:0]         digit_idx_q, digit_idx_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_on_q, blink_on_d;
  logic [7:0]         snap_num_q, snap_num_d;
  logic               snap_to_q, snap_to_d;
  logic               snap_stop_q, snap_stop_d;
  logic [3:0]         an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;

  logic scan_wrap, blink_wrap, frame_end, blank;
  logic [6:0] seg_digit;

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  assign scan_wrap  = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
  assign blink_wrap = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
  assign frame_end  = scan_wrap && (digit_idx_q == 2'd3);

  // Timebase: digit scan, frame-boundary snapshot and free-running blink
  always_comb begin
    scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
    digit_idx_d = scan_wrap ? digit_idx_q + 2'd1 : digit_idx_q;
    blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + BLINK_W'(1);
    blink_on_d  = blink_wrap ? ~blink_on_q : blink_on_q;
    snap_num_d  = frame_end ? number  : snap_num_q;
    snap_to_d   = frame_end ? timeout : snap_to_q;
    snap_stop_d = frame_end ? stop    : snap_stop_q;
  end

  // Output stage: everything here comes from registered state only
  always_comb begin
    blank = snap_to_q && !blink_on_q;
    case (digit_idx_q)
      2'd0: seg_digit = encode(snap_num_q[3:0]);
      2'd1: begin
`ifdef SEG_TIME_DISPLAY_LZB_EN
        seg_digit = (snap_num_q[7:4] == 4'd0) ? 7'h7F : encode(snap_num_q[7:4]);
`else
        seg_digit = encode(snap_num_q[7:4]);
`endif
      end
      2'd2:    seg_digit = 7'h7F;
      default: seg_digit = snap_stop_q ? 7'h0C : 7'h7F;
    endcase
    an_d  = blank ? 4'b1111 : ~(4'b0001 << digit_idx_q);
    seg_d = blank ? 7'h7F : seg_digit;
    dp_d  = ~((digit_idx_q == 2'd3) && snap_to_q && !blank);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q  <= '0;
      digit_idx_q <= 2'd0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      snap_num_q  <= 8'h00;
      snap_to_q   <= 1'b0;
      snap_stop_q <= 1'b0;
      an_q        <= 4'b1111;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      digit_idx_q <= digit_idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      snap_num_q  <= snap_num_d;
      snap_to_q   <= snap_to_d;
      snap_stop_q <= snap_stop_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg_time_display.sv
// Bench for seg_time_display: time-index reference model of scan, snapshot and blink.
module tb_seg_time_display;

  localparam int S = 4;
  localparam int B = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] number = 8'h00;
  logic       timeout = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int passed = 0;

  // Model: n = clock edges since reset released, plus the frame snapshot.
  int         n = 0;
  logic [7:0] m_num = 8'h00;
  logic       m_to = 1'b0;
  logic       m_stop = 1'b0;

  seg_time_display #(.SCAN_DIV(S), .BLINK_DIV(B)) dut (
    .clk(clk), .rst(rst), .number(number), .timeout(timeout), .stop(stop),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] tbl [0:9];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return (d > 4'd9) ? 7'h3F : tbl[d];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, n);
  endtask

  task automatic tick();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    int         d;
    logic       lit;
    if (rst) begin
      e_an = 4'b1111; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      d   = (n / S) % 4;
      lit = !(m_to && ((n / B) % 2 == 1));
      case (d)
        0: e_seg = glyph(m_num[3:0]);
`ifdef SEG_TIME_DISPLAY_LZB_EN
        1: e_seg = (m_num[7:4] == 4'd0) ? 7'h7F : glyph(m_num[7:4]);
`else
        1: e_seg = glyph(m_num[7:4]);
`endif
        2: e_seg = 7'h7F;
        default: e_seg = m_stop ? 7'h0C : 7'h7F;
      endcase
      e_an = 4'b1111;
      e_an[d] = 1'b0;
      e_dp = !(d == 3 && m_to);
      if (!lit) begin
        e_an = 4'b1111; e_seg = 7'h7F; e_dp = 1'b1;
      end
    end
    @(posedge clk);
    if (rst) begin
      n = 0; m_num = 8'h00; m_to = 1'b0; m_stop = 1'b0;
    end else begin
      n++;
      if (n % (4 * S) == 0) begin
        m_num = number; m_to = timeout; m_stop = stop;
      end
    end
    @(negedge clk);
    check("an", 32'(an), 32'(e_an));
    check("seg", 32'(seg), 32'(e_seg));
    check("dp", 32'(dp), 32'(e_dp));
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  initial begin
    // Reset and idle scan of 00
    rst = 1'b1;
    run(3);
    check("rst_an", 32'(an), 32'h0000000F);
    rst = 1'b0;
    tick();
    check("first_an", 32'(an), 32'b1110);
    check("first_seg", 32'(seg), 32'h40);
    run(4);
    check("dig1_an", 32'(an), 32'b1101);
    check("dig1_seg", 32'(seg), 32'h40);
    run(27);

    // Mid-frame change, then invalid ones digit
    run(5);
    number = 8'h27;
    run(40);
    number = 8'h3C;
    run(36);

    // Latched timeout and stop: blink with 'P' and dp
    number = 8'h30; timeout = 1'b1; stop = 1'b1;
    run(96);

    // One-cycle reset while digit 2 is being scanned
    for (int i = 0; i < 16 && ((n / S) % 4) != 2; i++) tick();
    rst = 1'b1;
    tick();
    check("midrst_an", 32'(an), 32'h0000000F);
    check("midrst_seg", 32'(seg), 32'h7F);
    rst = 1'b0; timeout = 1'b0; stop = 1'b0;
    tick();
    check("post_rst_an", 32'(an), 32'b1110);
    check("post_rst_seg", 32'(seg), 32'h40);
    run(20);

    // Randomized inputs held for random durations
    for (int it = 0; it < 24; it++) begin
      number  = 8'($urandom);
      timeout = 1'($urandom_range(0, 1));
      stop    = 1'($urandom_range(0, 1));
      run($urandom_range(1, 40));
    end

    // Tens-digit zero handling on a clean frame
    rst = 1'b1; timeout = 1'b0; stop = 1'b0; number = 8'h05;
    tick();
    rst = 1'b0;
    run(17);
    check("d0_05_an", 32'(an), 32'b1110);
    check("d0_05_seg", 32'(seg), 32'h12);
    run(4);
    check("d1_05_an", 32'(an), 32'b1101);
`ifdef SEG_TIME_DISPLAY_LZB_EN
    check("d1_05_seg", 32'(seg), 32'h7F);
`else
    check("d1_05_seg", 32'(seg), 32'h40);
`endif
    run(12);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/seg_time_display.md
Name: seg_time_display

Overview:
- Display-side consumer of the seconds counter's BCD value (number[7:0]) and its timeout/stop status.
- Time-multiplexes a 4-digit common-anode 7-segment display:
  - digit0 = seconds ones
  - digit1 = seconds tens
  - digit2 = blank
  - digit3 = status
- Snapshots inputs once per scan frame so that a digit update never tears mid-frame.
- Blinks the whole display while timeout is held.

Parameters:
- SCAN_DIV, 12500, clk cycles each digit is driven (50 MHz -> 4 kHz digit rate, 1 kHz frame rate); must be >= 2.
- BLINK_DIV, 12500000, clk cycles per blink half-period (0.25 s at 50 MHz); must be >= 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- number  in  8  BCD seconds; [7:4] tens, [3:0] ones
- timeout  in  1  time limit reached
- stop  in  1  counting halted
- an  out  4  digit anodes, active-low; an[0] = digit0
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low

Behaviour:
- Clock and reset:
  - Single clock domain (clk).
  - rst is synchronous and active-high, sampled on posedge clk.
- Reset values:
  - an = 4'b1111, seg = 7'h7F, dp = 1.
  - scan_cnt = 0, digit_idx = 0, blink_cnt = 0, blink_on = 1.
  - snap_num = 8'h00, snap_to = 0, snap_stop = 0.
- Scan counter:
  - scan_cnt counts 0..SCAN_DIV-1, then wraps to 0.
  - On wrap, digit_idx advances 0->1->2->3->0 (2-bit wrap).
- Snapshot:
  - Loaded on the cycle where scan_cnt wraps while digit_idx == 3.
  - Loads snap_num <= number, snap_to <= timeout, snap_stop <= stop.
  - Otherwise holds. Input changes are reflected only from the next frame.
  - Worst-case display latency from an input change is 4*SCAN_DIV + 1 cycles.
- Blink:
  - blink_cnt counts 0..BLINK_DIV-1; on wrap, blink_on toggles.
  - Free-running regardless of timeout.
- Output registers (one cycle after digit_idx/snapshot/blink_on change):
  - If snap_to == 1 and blink_on == 0: an = 4'b1111 and seg = 7'h7F (all dark).
  - Otherwise an = ~(4'b0001 << digit_idx).
- seg per digit:
  - idx0: encode(snap_num[3:0])
  - idx1: encode(snap_num[7:4])
  - idx2: 7'h7F
  - idx3: 7'h0C ('P') if snap_stop, else 7'h7F
- encode():
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19, 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10 (hex).
  - Nibbles A..F encode as dash 7'h3F.
- dp: 0 only when digit_idx == 3, snap_to == 1 and the display is not blanked; otherwise 1.
- Simultaneous events: the snapshot load and the digit_idx 3->0 advance occur in the same cycle. Digit0 of the new frame shows the new snapshot.
- Reset mid-frame: all state returns to reset values on the next edge. The first post-reset digit shown is digit0 = '0' (an = 1110, seg = 40) from the cycle after rst deasserts.
- Latched status: timeout asserted and stop asserted both display; digit3 shows 'P' with dp lit, blinking.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: SEG_TIME_DISPLAY_LZB_EN (leading-zero blanking).
- Defined: digit1 shows 7'h7F when snap_num[7:4] == 0.
- Undefined: digit1 always shows encode(snap_num[7:4]), so 8'h07 displays "07".

Test Plan:
All scenarios use SCAN_DIV = 4 and BLINK_DIV = 16.
- Reset, then hold number = 8'h00 -> cycle after rst low: an = 1110, seg = 40. After 4 cycles: an = 1101, seg = 40. Then an = 1011 and 0111 with seg = 7F. Repeats every 16 cycles.
- number = 8'h27 applied mid-frame -> current frame still shows 00. From the next frame: digit0 seg = 78, digit1 seg = 24.
- number = 8'h3C (invalid ones) -> digit0 seg = 3F, digit1 seg = 30.
- timeout = 1, stop = 1, number = 8'h30 -> after the next frame boundary, an = 1111 for 16-cycle windows alternating with normal scan. Digit3 seg = 0C with dp = 0 when lit.
- rst asserted for 1 cycle while digit_idx = 2 and timeout is latched -> next cycle outputs all-off. Then digit0 shows '0', snap_to = 0, no blanking.
- With SEG_TIME_DISPLAY_LZB_EN defined, number = 8'h05 -> digit1 seg = 7F, digit0 seg = 12. Undefined: digit1 seg = 40.
